// File: rtl/sap_program_ram.sv
// SAP-1 program/data memory: registered read port, CPU write port, streaming
// loader that fills from address 0, and an optional post-reset clear sweep.
module sap_program_ram #(
    parameter int DATA_W         = 8,
    parameter int ADDR_W         = 4,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              read_en,
    input  logic [ADDR_W-1:0] read_addr,
    output logic [DATA_W-1:0] read_data,
    output logic              read_valid,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              load_done,
    output logic [ADDR_W:0]   load_count,
    output logic              busy
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_LOAD  = 2'd2
    } state_t;

    localparam state_t RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] ptr_reg, ptr_next;
    logic [ADDR_W:0]   count_reg, count_next;
    logic              done_reg, done_next;
    logic [DATA_W-1:0] rdata_reg;
    logic              rvalid_reg;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem [DEPTH];

    // One shared write port: the clear sweep, loader beats and CPU writes are
    // mutually exclusive by state, so a simple mux feeds the array.
    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        count_next = count_reg;
        done_next  = 1'b0;
        mem_we     = 1'b0;
        mem_waddr  = wr_addr;
        mem_wdata  = wr_data;
        case (state_reg)
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = ptr_reg;
                mem_wdata = '0;
                if (ptr_reg == LAST_ADDR) begin
                    state_next = ST_IDLE;
                    ptr_next   = '0;
                end else begin
                    ptr_next = ptr_reg + 1'b1;
                end
            end
            ST_IDLE: begin
                mem_we = wr_en;
                if (load_start) begin
                    state_next = ST_LOAD;
                    ptr_next   = '0;
                    count_next = '0;
                end
            end
            ST_LOAD: begin
                if (load_valid) begin
                    mem_we     = 1'b1;
                    mem_waddr  = ptr_reg;
                    mem_wdata  = load_data;
                    count_next = count_reg + 1'b1;
                    // No wrap: the final address ends the load even without load_last.
                    if (load_last || ptr_reg == LAST_ADDR) begin
                        state_next = ST_IDLE;
                        ptr_next   = '0;
                        done_next  = 1'b1;
                    end else begin
                        ptr_next = ptr_reg + 1'b1;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= RESET_STATE;
            ptr_reg    <= '0;
            count_reg  <= '0;
            done_reg   <= 1'b0;
            rdata_reg  <= '0;
            rvalid_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            ptr_reg    <= ptr_next;
            count_reg  <= count_next;
            done_reg   <= done_next;
            rvalid_reg <= 1'b0;
            if (state_reg == ST_IDLE && read_en) begin
                rdata_reg  <= mem[read_addr];
                rvalid_reg <= 1'b1;
            end
        end
    end

    // Array itself is never reset; a same-edge write is seen only by later reads.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign read_data  = rdata_reg;
    assign read_valid = rvalid_reg;
    assign load_ready = (state_reg == ST_LOAD);
    assign load_done  = done_reg;
    assign load_count = count_reg;
    assign busy       = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_sap_program_ram.sv
// Scoreboard bench for sap_program_ram: reads push expected words, the
// read_valid monitor pops and compares data and arrival cycle.
module tb_sap_program_ram;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       read_en = 1'b0;
    logic [3:0] read_addr = '0;
    logic [7:0] read_data;
    logic       read_valid;
    logic       wr_en = 1'b0;
    logic [3:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       load_start = 1'b0;
    logic       load_valid = 1'b0;
    logic [7:0] load_data = '0;
    logic       load_last = 1'b0;
    logic       load_ready;
    logic       load_done;
    logic [4:0] load_count;
    logic       busy;

    sap_program_ram #(.DATA_W(8), .ADDR_W(4), .CLEAR_ON_RESET(1'b1)) dut (
        .clk(clk), .rst(rst),
        .read_en(read_en), .read_addr(read_addr), .read_data(read_data), .read_valid(read_valid),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
        .load_last(load_last), .load_ready(load_ready), .load_done(load_done),
        .load_count(load_count), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        int         due;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] model [16];
    logic [7:0] prog [16];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         done_pulses = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst) begin
            if (load_done) done_pulses++;
            if (read_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_read_valid", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("read_data", {24'd0, read_data}, {24'd0, e.data});
                    check("read_latency", cyc, e.due);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input int a);
        exp_t e;
        read_en   = 1'b1;
        read_addr = 4'(a);
        e.data = model[a];
        e.due  = cyc + 1;
        sb.push_back(e);
        $display("read  addr=%0d expect=%02h", a, model[a]);
        step();
        read_en = 1'b0;
    endtask

    task automatic read_all();
        for (int a = 0; a < 16; a++) do_read(a);
        step();
        step();
    endtask

    task automatic wait_clear();
        int n;
        n = 0;
        while (busy && n < 40) begin
            step();
            n++;
        end
        check("clear_busy_cycles", n, 16);
        for (int a = 0; a < 16; a++) model[a] = 8'h00;
    endtask

    // Loads prog[0..n-1]; optional idle gaps with CPU read/write pokes in them.
    task automatic run_load(input int n, input bit use_last, input int gap,
                            input bit poke, input bit wr_start, input int exp_count);
        int d0;
        d0 = done_pulses;
        load_start = 1'b1;
        if (wr_start) begin
            wr_en = 1'b1; wr_addr = 4'd9; wr_data = 8'h3C;
            model[9] = 8'h3C;
        end
        step();
        load_start = 1'b0;
        wr_en = 1'b0;
        check("load_ready_after_start", load_ready, 1);
        check("busy_in_load", busy, 1);
        for (int i = 0; i < n; i++) begin
            load_valid = 1'b1;
            load_data  = prog[i];
            load_last  = use_last && (i == n - 1);
            model[i]   = prog[i];
            $display("load  beat=%0d data=%02h last=%0b", i, prog[i], load_last);
            step();
            load_valid = 1'b0;
            load_last  = 1'b0;
            if (i < n - 1) begin
                for (int g = 0; g < gap; g++) begin
                    if (poke) begin
                        read_en = 1'b1; read_addr = 4'(i);
                        wr_en = 1'b1; wr_addr = 4'd10; wr_data = 8'h77;
                    end
                    step();
                    read_en = 1'b0;
                    wr_en = 1'b0;
                end
            end
        end
        check("load_done_pulse", load_done, 1);
        check("load_ready_at_done", load_ready, 0);
        check("busy_at_done", busy, 0);
        check("load_count", load_count, exp_count);
        step();
        check("load_done_cleared", load_done, 0);
        check("load_done_count", done_pulses - d0, 1);
        check("load_count_held", load_count, exp_count);
    endtask

    initial begin
        // Reset state (held in reset)
        repeat (3) @(posedge clk);
        #1;
        check("rst_read_data", read_data, 0);
        check("rst_read_valid", read_valid, 0);
        check("rst_load_ready", load_ready, 0);
        check("rst_load_done", load_done, 0);
        check("rst_load_count", load_count, 0);
        check("rst_busy", busy, 1);
        rst = 1'b0;

        // Test 1: clear sweep, all zero
        wait_clear();
        read_all();

        // Test 2: full 16-word load ends at last address
        prog = '{8'h09, 8'h1A, 8'h1B, 8'h2C, 8'hEF, 8'h09, 8'h1C, 8'hEF,
                 8'hFF, 8'h01, 8'h02, 8'h03, 8'h04, 8'hFF, 8'hFF, 8'hFF};
        run_load(16, 1'b0, 0, 1'b0, 1'b0, 16);
        read_all();

        // Test 3: short load with load_last; CPU write in the start cycle
        prog[0] = 8'hAA; prog[1] = 8'hBB; prog[2] = 8'hCC;
        run_load(3, 1'b1, 0, 1'b0, 1'b1, 3);
        read_all();

        // Tests 4/5: gapped loader, CPU read/write attempted in the gaps
        prog[0] = 8'h11; prog[1] = 8'h22; prog[2] = 8'h33; prog[3] = 8'h44; prog[4] = 8'h55;
        run_load(5, 1'b1, 2, 1'b1, 1'b0, 5);
        read_all();

        // Test 6: read-first on same-address read/write
        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 8'h55;
        do_read(5);
        wr_en = 1'b0;
        model[5] = 8'h55;
        do_read(5);
        do_write_gap: begin
            wr_en = 1'b1; wr_addr = 4'd12; wr_data = 8'hA5;
            step();
            wr_en = 1'b0;
            model[12] = 8'hA5;
        end
        do_read(12);
        step();
        step();

        // Test 7: reset after two loader beats aborts and re-clears
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        load_valid = 1'b1;
        load_data = 8'hDE;
        step();
        load_data = 8'hAD;
        step();
        rst = 1'b1;
        #1;
        check("abort_load_ready", load_ready, 0);
        check("abort_busy", busy, 1);
        check("abort_load_count", load_count, 0);
        load_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
        wait_clear();
        read_all();

        repeat (3) step();
        check("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

endmodule
